bus_bridge: RTL and testbench

//  Single-clock bridge between the CPU data bus and its targets: synchronous block RAM with a

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_io_regs.sv | 92 +++++++++
 rtl/bus_bridge.sv | 175 +++++++++++++++++
 tb/tb_bus_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus bridge: FSM state encoding and the
// register offsets inside the 16-word memory-mapped I/O window.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word offsets inside the I/O window
  localparam logic [3:0] LED    = 4'd0;
  localparam logic [3:0] CNT_LO = 4'd1;
  localparam logic [3:0] CNT_HI = 4'd2;
  localparam logic [3:0] STATUS = 4'd3;

  localparam int IO_WINDOW = 16;

endpackage

// File: rtl/bus_io_regs.sv
// Memory-mapped I/O register file of the bus bridge.
// Holds the LED register, the free-running 32-bit cycle counter with its
// high-half snapshot, and the sticky fault status bit.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_en, rd_en  one-cycle access strobes (already decoded to this window)
//   offset        word offset inside the window
//   wdata         write data bits this block can use
//   fault_set     sets the sticky fault bit (wins over a clear)
//   rdata         combinational read data for the addressed register
//   led_out       LED register contents
module bus_io_regs
  import bus_pkg::*;
#(
  parameter int          DATA_WIDTH    = 16,
  parameter int          LED_WIDTH     = 10,
  // Counter value after reset; 0 in normal use
  parameter logic [31:0] COUNTER_RESET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [3:0]            offset,
  input  logic [LED_WIDTH-1:0]  wdata,
  input  logic                  fault_set,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [LED_WIDTH-1:0]  led_out
);

  logic [LED_WIDTH-1:0] led_r;
  logic [31:0]          counter_r;
  logic [15:0]          cnt_hi_r;
  logic                 status_r;

  // LED register: written through offset LED
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_r <= {LED_WIDTH{1'b0}};
    end else if (wr_en && (offset == LED)) begin
      led_r <= wdata;
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_r <= COUNTER_RESET;
    end else begin
      counter_r <= counter_r + 32'd1;
    end
  end

  // Reading CNT_LO freezes the matching high half so CNT_HI returns a consistent pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_hi_r <= 16'h0000;
    end else if (rd_en && (offset == CNT_LO)) begin
      cnt_hi_r <= counter_r[31:16];
    end
  end

  // Sticky fault bit: a new fault has priority over a write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r <= 1'b0;
    end else if (fault_set) begin
      status_r <= 1'b1;
    end else if (wr_en && (offset == STATUS) && wdata[0]) begin
      status_r <= 1'b0;
    end
  end

  // Read mux; unused offsets read as zero
  always_comb begin
    rdata = {DATA_WIDTH{1'b0}};
    if (rd_en) begin
      case (offset)
        LED:     rdata = DATA_WIDTH'(led_r);
        CNT_LO:  rdata = DATA_WIDTH'(counter_r[15:0]);
        CNT_HI:  rdata = DATA_WIDTH'(cnt_hi_r);
        STATUS:  rdata = DATA_WIDTH'(status_r);
        default: rdata = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
    end
  end

  assign led_out = led_r;

endmodule

// File: rtl/bus_bridge.sv
// Single-clock bridge between the CPU data bus, a synchronous block RAM with
// RAM_LATENCY read latency, and the I/O register window. Adds a one-cycle
// cpu_ready completion pulse (cpu_fault alongside it for bad accesses).
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   cpu_addr/wdata/read/write  CPU request, strobes held until cpu_ready
//   cpu_rdata/ready/fault  CPU completion
//   ram_addr/wdata/rden/wren/q  RAM macro interface (enables combinational)
//   led_out                LED register contents
module bus_bridge
  import bus_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 20,
  parameter int          DATA_WIDTH    = 16,
  parameter int unsigned RAM_BASE      = 32'h0000_0000,
  parameter int unsigned RAM_DEPTH     = 1024,
  parameter int          RAM_LATENCY   = 1,
  parameter int unsigned IO_BASE       = 32'h000F_0000,
  parameter int          LED_WIDTH     = 10,
  // Counter value after reset; 0 in normal use
  parameter logic [31:0] COUNTER_RESET = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic [DATA_WIDTH-1:0]        cpu_wdata,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  output logic [DATA_WIDTH-1:0]        cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_fault,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  output logic                         ram_rden,
  output logic                         ram_wren,
  input  logic [DATA_WIDTH-1:0]        ram_q,
  output logic [LED_WIDTH-1:0]         led_out
);

  localparam int          RAM_AW   = $clog2(RAM_DEPTH);
  localparam logic [1:0]  LAT_LAST = 2'(RAM_LATENCY - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [1:0]            lat_cnt_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  fault_r;

  logic [32:0]           ram_off_s;
  logic [32:0]           io_off_s;
  logic                  in_ram_s;
  logic                  in_io_s;
  logic                  accept_s;
  logic                  both_s;
  logic                  fault_s;
  logic                  ram_rd_s;
  logic                  ram_wr_s;
  logic                  io_rd_s;
  logic                  io_wr_s;
  logic                  last_busy_s;
  logic [DATA_WIDTH-1:0] io_rdata_s;

  // Offsets are taken in 33 bits so an address below a window base wraps to a
  // huge value and fails the single upper-bound compare.
  assign ram_off_s = 33'(cpu_addr) - 33'(RAM_BASE);
  assign io_off_s  = 33'(cpu_addr) - 33'(IO_BASE);
  assign in_ram_s  = ram_off_s < 33'(RAM_DEPTH);
  assign in_io_s   = io_off_s < 33'(IO_WINDOW);

  // Request decode; reset_n gating keeps the RAM enables quiet during reset
  always_comb begin
    accept_s = reset_n && (state_r == IDLE) && (cpu_read || cpu_write);
    both_s   = cpu_read && cpu_write;
    fault_s  = accept_s && (both_s || !(in_ram_s || in_io_s));
    // RAM wins where the windows overlap
    ram_rd_s = accept_s && !both_s && in_ram_s && cpu_read;
    ram_wr_s = accept_s && !both_s && in_ram_s && cpu_write;
    io_rd_s  = accept_s && !both_s && !in_ram_s && in_io_s && cpu_read;
    io_wr_s  = accept_s && !both_s && !in_ram_s && in_io_s && cpu_write;
    last_busy_s = (state_r == BUSY) && (lat_cnt_r == LAT_LAST);
  end

  // Next-state logic: only RAM reads wait in BUSY
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ram_rd_s) begin
          state_nxt_s = BUSY;
        end else if (accept_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_busy_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counts cycles spent in BUSY, restarts whenever the FSM leaves it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt_r <= 2'd0;
    end else if (state_r == BUSY) begin
      lat_cnt_r <= lat_cnt_r + 2'd1;
    end else begin
      lat_cnt_r <= 2'd0;
    end
  end

  // Fault flag captured at acceptance and presented during DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_r <= 1'b0;
    end else if (accept_s) begin
      fault_r <= fault_s;
    end
  end

  // Read data: I/O value frozen at acceptance, RAM data taken on the last BUSY cycle,
  // everything else (writes, faults) returns zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (io_rd_s) begin
      rdata_r <= io_rdata_s;
    end else if (last_busy_s) begin
      rdata_r <= ram_q;
    end else if (accept_s) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end
  end

  bus_io_regs #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LED_WIDTH    (LED_WIDTH),
    .COUNTER_RESET(COUNTER_RESET)
  ) u_io_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (io_wr_s),
    .rd_en    (io_rd_s),
    .offset   (io_off_s[3:0]),
    .wdata    (cpu_wdata[LED_WIDTH-1:0]),
    .fault_set(fault_s),
    .rdata    (io_rdata_s),
    .led_out  (led_out)
  );

  assign ram_addr  = ram_off_s[RAM_AW-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_rden  = ram_rd_s;
  assign ram_wren  = ram_wr_s;
  assign cpu_ready = (state_r == DONE);
  assign cpu_fault = (state_r == DONE) && fault_r;
  assign cpu_rdata = rdata_r;

endmodule

// File: tb/tb_bus_bridge.sv
// Scoreboard bench for bus_bridge: four instances with RAM_LATENCY 1..4.
// The stimulus pushes the expected completion of every request into a queue;
// a monitor per instance pops and compares on each cpu_ready pulse.
module tb_bus_bridge;

  typedef enum {K_RAMRD, K_RAMWR, K_IO, K_FAULT} kind_e;

  typedef struct {
    logic [15:0] rdata;
    logic        fault;
    int          lat;
    int          t;
    logic [9:0]  addr;
    logic [15:0] wdata;
    int          n_rd;
    int          n_wr;
  } exp_t;

  int   checks;
  int   failures;
  int   cyc;
  logic clk;
  bit   done [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int L = g + 1;

    logic        reset_n;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_fault;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_rden;
    logic        ram_wren;
    logic [15:0] ram_q;
    logic [9:0]  led_out;

    bus_bridge #(
      .RAM_LATENCY  (L),
      .COUNTER_RESET(32'hFFFF_FFFE)
    ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_read (cpu_read),
      .cpu_write(cpu_write),
      .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready),
      .cpu_fault(cpu_fault),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rden (ram_rden),
      .ram_wren (ram_wren),
      .ram_q    (ram_q),
      .led_out  (led_out)
    );

    // RAM model: data valid exactly L cycles after ram_rden
    logic [15:0] mem  [1024];
    logic [15:0] pipe [L];
    always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      pipe[0] <= ram_rden ? mem[ram_addr] : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[L-1];

    // Reference cycle counter and CNT_HI snapshot
    logic [31:0] m_cnt;
    logic [15:0] snap;
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_cnt <= 32'hFFFF_FFFE;
      else          m_cnt <= m_cnt + 32'd1;
    end

    exp_t q[$];

    // Issues one request at the start of a cycle and waits for its ready pulse.
    // cnt_sel: 1 = expect counter low half (and take snapshot), 2 = expect snapshot.
    task automatic req(input kind_e k, input logic rd, input logic wr, input logic [19:0] addr,
                       input logic [15:0] wd, input logic [15:0] er, input int cnt_sel);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      if (cnt_sel == 1) begin
        er   = m_cnt[15:0];
        snap = m_cnt[31:16];
      end else if (cnt_sel == 2) begin
        er = snap;
      end
      e.t     = cyc;
      e.addr  = addr[9:0];
      e.wdata = wd;
      e.rdata = er;
      e.fault = (k == K_FAULT);
      e.lat   = (k == K_RAMRD) ? L + 1 : 1;
      e.n_rd  = (k == K_RAMRD) ? 1 : 0;
      e.n_wr  = (k == K_RAMWR) ? 1 : 0;
      q.push_back(e);
      cpu_addr  = addr;
      cpu_wdata = wd;
      cpu_read  = rd;
      cpu_write = wr;
      for (n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (cpu_ready) break;
      end
      if (n == 12) check($sformatf("L%0d ready timeout addr=%h", L, addr), 32'd0, 32'd1);
    endtask

    task automatic idle();
      @(posedge clk); #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
    endtask

    // Monitor: counts RAM strobes per transaction and checks each completion
    initial begin
      int   rd_p;
      int   wr_p;
      exp_t e;
      rd_p = 0;
      wr_p = 0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          rd_p = 0;
          wr_p = 0;
        end else begin
          if (ram_rden || ram_wren) begin
            rd_p += int'(ram_rden);
            wr_p += int'(ram_wren);
            if (q.size() > 0) begin
              check($sformatf("L%0d ram_addr", L), 32'(ram_addr), 32'(q[0].addr));
              if (ram_wren) check($sformatf("L%0d ram_wdata", L), 32'(ram_wdata), 32'(q[0].wdata));
            end
          end
          if (cpu_fault && !cpu_ready) check($sformatf("L%0d stray fault", L), 32'd1, 32'd0);
          if (cpu_ready) begin
            if (q.size() == 0) begin
              check($sformatf("L%0d unexpected ready", L), 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              check($sformatf("L%0d rdata", L), 32'(cpu_rdata), 32'(e.rdata));
              check($sformatf("L%0d fault", L), 32'(cpu_fault), 32'(e.fault));
              check($sformatf("L%0d latency", L), 32'(cyc - e.t), 32'(e.lat));
              check($sformatf("L%0d rden count", L), 32'(rd_p), 32'(e.n_rd));
              check($sformatf("L%0d wren count", L), 32'(wr_p), 32'(e.n_wr));
            end
            rd_p = 0;
            wr_p = 0;
          end
        end
      end
    end

    if (g == 0) begin : g_full
      initial begin
        reset_n = 1'b1; cpu_addr = 20'h00005; cpu_wdata = 16'h0000;
        cpu_read = 1'b1; cpu_write = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset ready", 32'(cpu_ready), 32'd0);
        check("reset fault", 32'(cpu_fault), 32'd0);
        check("reset rdata", 32'(cpu_rdata), 32'd0);
        check("reset led", 32'(led_out), 32'd0);
        check("reset rden", 32'(ram_rden), 32'd0);
        cpu_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Counter pair across the 32-bit wrap
        req(K_IO, 1'b1, 1'b0, 20'hF0001, 16'h0000, 16'h0000, 1);
        req(K_IO, 1'b1, 1'b0, 20'hF0002, 16'h0000, 16'h0000, 2);
        req(K_IO, 1'b1, 1'b0, 20'hF0001, 16'h0000, 16'h0000, 1);
        req(K_IO, 1'b1, 1'b0, 20'hF0002, 16'h0000, 16'h0000, 2);

        // RAM write/read, including the last word of the window
        req(K_RAMWR, 1'b0, 1'b1, 20'h00005, 16'h1234, 16'h0000, 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00005, 16'h0000, 16'h1234, 0);
        req(K_RAMWR, 1'b0, 1'b1, 20'h003FF, 16'hBEEF, 16'h0000, 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h003FF, 16'h0000, 16'hBEEF, 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00005, 16'h0000, 16'h1234, 0);

        // LED register and the quiet part of the I/O window
        req(K_IO, 1'b0, 1'b1, 20'hF0000, 16'hFFFF, 16'h0000, 0);
        check("led after 0xFFFF", 32'(led_out), 32'h3FF);
        req(K_IO, 1'b1, 1'b0, 20'hF0000, 16'h0000, 16'h03FF, 0);
        req(K_IO, 1'b0, 1'b1, 20'hF0000, 16'h0155, 16'h0000, 0);
        check("led after 0x0155", 32'(led_out), 32'h155);
        req(K_IO, 1'b1, 1'b0, 20'hF0000, 16'h0000, 16'h0155, 0);
        req(K_IO, 1'b0, 1'b1, 20'hF0002, 16'h1234, 16'h0000, 0);
        req(K_IO, 1'b1, 1'b0, 20'hF0002, 16'h0000, 16'h0000, 2);
        req(K_IO, 1'b0, 1'b1, 20'hF0005, 16'hAAAA, 16'h0000, 0);
        req(K_IO, 1'b1, 1'b0, 20'hF0005, 16'h0000, 16'h0000, 0);
        req(K_IO, 1'b1, 1'b0, 20'hF000F, 16'h0000, 16'h0000, 0);
        req(K_IO, 1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0000, 0);
        check("led unchanged", 32'(led_out), 32'h155);

        // Faults and the sticky status bit
        req(K_IO,    1'b1, 1'b0, 20'hF0000, 16'h0000, 16'h0155, 0);
        req(K_FAULT, 1'b1, 1'b0, 20'h80000, 16'h0000, 16'h0000, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0001, 0);
        req(K_FAULT, 1'b1, 1'b1, 20'h00005, 16'hFFFF, 16'h0000, 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00005, 16'h0000, 16'h1234, 0);
        req(K_FAULT, 1'b1, 1'b0, 20'hF0010, 16'h0000, 16'h0000, 0);
        req(K_FAULT, 1'b0, 1'b1, 20'h00400, 16'h5555, 16'h0000, 0);
        req(K_IO,    1'b0, 1'b1, 20'hF0003, 16'h0000, 16'h0000, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0001, 0);
        req(K_IO,    1'b0, 1'b1, 20'hF0003, 16'h0001, 16'h0000, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0000, 0);
        check("led after faults", 32'(led_out), 32'h155);

        // Reset during BUSY abandons the read
        @(posedge clk); #1;
        cpu_addr = 20'h00005; cpu_read = 1'b1; cpu_write = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        check("midreset ready", 32'(cpu_ready), 32'd0);
        check("midreset fault", 32'(cpu_fault), 32'd0);
        check("midreset rdata", 32'(cpu_rdata), 32'd0);
        check("midreset led", 32'(led_out), 32'd0);
        check("midreset rden", 32'(ram_rden), 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          check("ready held off in reset", 32'(cpu_ready), 32'd0);
        end
        cpu_read = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        req(K_RAMRD, 1'b1, 1'b0, 20'h00005, 16'h0000, 16'h1234, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0000, 16'h0000, 16'h0000, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0000, 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0001, 16'h0000, 16'h0000, 1);
        idle();
        repeat (3) @(posedge clk);
        done[g] = 1'b1;
      end
    end else begin : g_sweep
      initial begin
        reset_n = 1'b1; cpu_addr = 20'h00000; cpu_wdata = 16'h0000;
        cpu_read = 1'b0; cpu_write = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        req(K_RAMWR, 1'b0, 1'b1, 20'h00001, 16'h1100 + 16'(g), 16'h0000, 0);
        req(K_RAMWR, 1'b0, 1'b1, 20'h00002, 16'h2200 + 16'(g), 16'h0000, 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00001, 16'h0000, 16'h1100 + 16'(g), 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00002, 16'h0000, 16'h2200 + 16'(g), 0);
        req(K_RAMRD, 1'b1, 1'b0, 20'h00001, 16'h0000, 16'h1100 + 16'(g), 0);
        req(K_IO,    1'b1, 1'b0, 20'hF0003, 16'h0000, 16'h0000, 0);
        idle();
        repeat (3) @(posedge clk);
        done[g] = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait (done[0] && done[1] && done[2] && done[3]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
